uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_core transmitter between NUM_REQ byte-stream requesters.
- Each requester gets a valid/ready handshake. The arbiter latches one byte at a time and presents it to the core's data/valid_tx inputs.
- It sequences each frame using the core's busy_tx. A grant is held for bursts of up to MAX_BURST bytes, then passed on, to keep latency fair.
- Sits between the APB/packet front-ends and uart_core on the TX side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, max consecutive bytes per grant (1..255).
- IDW, $clog2(NUM_REQ), width of grant index (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle pulse; byte of requester i is taken.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- grant_id  out  IDW  index of current owner.
- tx_data  out  8  byte to uart_core data.
- tx_valid  out  1  to uart_core valid_tx.
- tx_busy  in  1  from uart_core busy_tx; frame in progress.
- arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst). All state changes on posedge clk.
- Reset values: state=IDLE, grant=0, grant_id=0, rr_ptr=0, burst_cnt=0, tx_data=8'h00, tx_valid=0, req_ready=0, arb_busy=0.
- States: IDLE, LATCH, SEND, WAIT_START, WAIT_END.
- IDLE:
  - If any req_valid: pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Set grant/grant_id, burst_cnt=0, go to LATCH.
  - Arbitration takes one cycle.
- LATCH:
  - If req_valid[grant_id]: pulse req_ready[grant_id] for exactly one cycle, register its byte into tx_data, go to SEND.
  - Otherwise (requester withdrew): release the grant, rr_ptr=grant_id+1, go to IDLE.
- SEND:
  - tx_valid=1.
  - Accept happens when tx_valid && !tx_busy. Then drop tx_valid on the next edge and go to WAIT_START.
  - tx_data stays stable from LATCH until accept.
- WAIT_START: wait for tx_busy=1, then go to WAIT_END. tx_valid=0, so no double send.
- WAIT_END, on tx_busy=0:
  - burst_cnt++.
  - If burst_cnt+1 < MAX_BURST and req_valid[grant_id]: go to LATCH, keeping the grant.
  - Otherwise: grant=0, rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
- Latency, request to tx_valid: 2 cycles from IDLE (IDLE→LATCH→SEND). Minimum gap between frames of the same burst is 2 cycles after busy falls.
- Wrap-around: rr_ptr and the search increment modulo NUM_REQ, including non-power-of-2 values.
- Simultaneous events:
  - A new req_valid during a burst is ignored until the grant is released.
  - req_valid changes on non-granted lines never affect the current owner.
- Reset mid-frame: the arbiter returns to IDLE immediately and no req_ready pulse is emitted. The core's in-flight frame is the core's responsibility.
- MAX_BURST=1 means strict per-byte round robin.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority. In IDLE it wins whenever req_valid[0], regardless of rr_ptr.
  - In WAIT_END, if req_valid[0] and owner!=0, the grant is released immediately, ending the burst early.
  - Requesters 1..N-1 round-robin among themselves; rr_ptr skips 0.
- Undefined: pure round robin as above.

Decomposition:
- Shared package uart_config gains:
  - typedef enum logic [2:0] uart_arb_state_t {IDLE, LATCH, SEND, WAIT_START, WAIT_END}.
  - localparam UART_BYTE_W=8.
- One sub-module: rr_pick, a combinational first-set-at-or-after-pointer priority encoder (NUM_REQ, ptr in, one-hot and index out). It is reused by the future RX dispatcher.

Test Plan:
- Single requester: req_valid=4'b0001, req_data[7:0]=8'h0F, loopback core → req_ready[0] pulses once, tx_valid 2 cycles after request, core valid_rx with rsr=8'h0F.
- All four valid, MAX_BURST=1, bytes A0/A1/A2/A3 → transmit order A0,A1,A2,A3,A0…; grant_id sequence 0,1,2,3,0.
- Requester 2 holds 10 bytes, MAX_BURST=8, requester 3 also valid → 8 bytes from 2, then grant_id=3, then remaining 2 from requester 2.
- Requester withdraws: req_valid[1] dropped between grant and LATCH → no req_ready, grant=0 next cycle, rr_ptr=2, no tx_valid.
- tx_busy held high for 40 cycles during SEND → tx_valid stays 1 and tx_data stable; exactly one frame sent after busy falls.
- rst asserted in WAIT_END → next cycle all outputs at reset values; with UART_TX_ARB_PRIO0_EN, req 0 and req 2 both valid → grant_id=0 first.

Source files
------------

// File: rtl/uart_config_pkg.sv
// Shared UART configuration: byte width and the TX arbiter state encoding.
package uart_config;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_START,
    WAIT_END
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational "first set bit at or after ptr" encoder, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDW-1:0]     pick_idx,
  output logic               pick_vld
);

  int             c;
  logic [IDW-1:0] ci;

  // Walk offsets from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    c        = 0;
    ci       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c  = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IDW'(c);
      if (req[ci]) begin
        pick_oh     = '0;
        pick_oh[ci] = 1'b1;
        pick_idx    = ci;
        pick_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_core transmitter between NUM_REQ byte streams.
// Optional macro UART_TX_ARB_PRIO0_EN: requester 0 gets strict priority over the round robin.
module uart_tx_arbiter
  import uart_config::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 8,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [IDW-1:0]                 grant_id,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_busy,
  output logic                           arb_busy
);

  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

  uart_arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [IDW-1:0]           gid_q, gid_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [7:0]               burst_q, burst_d;
  logic [UART_BYTE_W-1:0]   txd_q, txd_d;
  logic                     txv_q, txv_d;
  logic [NUM_REQ-1:0]       rdy_q, rdy_d;

  logic [NUM_REQ-1:0]       pick_req, pick_oh;
  logic [IDW-1:0]           pick_idx;
  logic                     pick_vld;
  logic [UART_BYTE_W-1:0]   sel_byte;
  logic                     keep_grant;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    logic [IDW-1:0] n;
    n = (p == IDW'(NUM_REQ - 1)) ? '0 : p + IDW'(1);
`ifdef UART_TX_ARB_PRIO0_EN
    if (n == '0) n = IDW'(1);
`endif
    return n;
  endfunction

`ifdef UART_TX_ARB_PRIO0_EN
  assign pick_req = req_valid & ~NUM_REQ'(1);
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (pick_req),
    .ptr      (rr_ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign sel_byte = req_data[{gid_q, 3'b000} +: UART_BYTE_W];

  // A burst continues only while under the cap and the owner still has data.
`ifdef UART_TX_ARB_PRIO0_EN
  assign keep_grant = (({1'b0, burst_q} + 9'd1) < BURST_LIM) && req_valid[gid_q]
                      && !(req_valid[0] && (gid_q != '0));
`else
  assign keep_grant = (({1'b0, burst_q} + 9'd1) < BURST_LIM) && req_valid[gid_q];
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    txd_d    = txd_q;
    txv_d    = txv_q;
    rdy_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          gid_d   = pick_idx;
          burst_d = '0;
          state_d = LATCH;
        end
`ifdef UART_TX_ARB_PRIO0_EN
        if (req_valid[0]) begin
          grant_d = NUM_REQ'(1);
          gid_d   = '0;
          burst_d = '0;
          state_d = LATCH;
        end
`endif
      end
      LATCH: begin
        if (req_valid[gid_q]) begin
          rdy_d   = grant_q;
          txd_d   = sel_byte;
          txv_d   = 1'b1;
          state_d = SEND;
        end else begin
          grant_d  = '0;
          rr_ptr_d = next_ptr(gid_q);
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          txv_d   = 1'b0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) state_d = WAIT_END;
      end
      WAIT_END: begin
        // Decisions wait for the frame to finish so the core is never handed a byte mid-frame.
        if (!tx_busy) begin
          burst_d = burst_q + 8'd1;
          if (keep_grant) begin
            state_d = LATCH;
          end else begin
            grant_d  = '0;
            rr_ptr_d = next_ptr(gid_q);
            state_d  = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        txv_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gid_q    <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      rdy_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
      rdy_q    <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (MAX_BURST=8 and MAX_BURST=1) with simple core models.
module tb_uart_tx_arbiter;
  import uart_config::*;

  localparam int N     = 4;
  localparam int FRAME = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N-1:0]   rv_a, rr_a, gr_a, rv_b, rr_b, gr_b;
  logic [N*8-1:0] rd_a, rd_b;
  logic [1:0]     gid_a, gid_b;
  logic [7:0]     txd_a, txd_b;
  logic           txv_a, txv_b, busy_a, busy_b, abusy_a, abusy_b;
  logic           hold_a;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_data(rd_a), .req_ready(rr_a),
    .grant(gr_a), .grant_id(gid_a), .tx_data(txd_a), .tx_valid(txv_a),
    .tx_busy(busy_a), .arb_busy(abusy_a));

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_data(rd_b), .req_ready(rr_b),
    .grant(gr_b), .grant_id(gid_b), .tx_data(txd_b), .tx_valid(txv_b),
    .tx_busy(busy_b), .arb_busy(abusy_b));

  // Core models: accept on valid && !busy, stay busy FRAME cycles, log {owner, byte}.
  logic        busy_r_a = 1'b0, busy_r_b = 1'b0;
  int          bcnt_a = 0, bcnt_b = 0;
  logic [15:0] log_a[$], log_b[$];
  assign busy_a = busy_r_a | hold_a;
  assign busy_b = busy_r_b;

  always @(posedge clk) begin
    if (bcnt_a > 0) begin
      bcnt_a <= bcnt_a - 1;
      if (bcnt_a == 1) busy_r_a <= 1'b0;
    end else if (txv_a && !busy_a) begin
      busy_r_a <= 1'b1;
      bcnt_a   <= FRAME;
      log_a.push_back({6'd0, gid_a, txd_a});
    end
  end

  always @(posedge clk) begin
    if (bcnt_b > 0) begin
      bcnt_b <= bcnt_b - 1;
      if (bcnt_b == 1) busy_r_b <= 1'b0;
    end else if (txv_b && !busy_b) begin
      busy_r_b <= 1'b1;
      bcnt_b   <= FRAME;
      log_b.push_back({6'd0, gid_b, txd_b});
    end
  end

  int         rem_a[N], rem_b[N], rdy_cnt_a[N];
  logic [7:0] dat_a[N], dat_b[N];
  int         checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rv_a[i]        = (rem_a[i] > 0);
      rd_a[i*8 +: 8] = dat_a[i];
      rv_b[i]        = (rem_b[i] > 0);
      rd_b[i*8 +: 8] = dat_b[i];
    end
  endtask

  // Advance to the next falling edge; requesters move to their next byte on a ready pulse.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rr_a[i]) begin
        rem_a[i]--;
        dat_a[i]++;
        rdy_cnt_a[i]++;
      end
      if (rr_b[i]) rem_b[i]--;
    end
    drive();
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((abusy_a || abusy_b || rv_a != 0 || rv_b != 0 || busy_a || busy_b) && n < 500) begin
      tick();
      n++;
    end
    check(tag, {31'd0, abusy_a | abusy_b | busy_a | busy_b}, 32'd0);
  endtask

  function automatic logic [15:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < log_a.size()) ? log_a[idx] : 16'hFFFF;
    return (idx < log_b.size()) ? log_b[idx] : 16'hFFFF;
  endfunction

  initial begin
    int         base, bad;
    logic [15:0] exp_e;
`ifdef UART_TX_ARB_PRIO0_EN
    int rr1_gid[8] = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    int rr1_gid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    rst    = 1'b1;
    hold_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem_a[i] = 0; rem_b[i] = 0; rdy_cnt_a[i] = 0;
      dat_a[i] = 8'h00; dat_b[i] = 8'h00;
    end
    drive();
    repeat (3) tick();
    check("rst_grant", gr_a, 0);
    check("rst_grant_id", gid_a, 0);
    check("rst_tx_data", txd_a, 0);
    check("rst_tx_valid", txv_a, 0);
    check("rst_req_ready", rr_a, 0);
    check("rst_arb_busy", abusy_a, 0);
    rst = 1'b0;
    tick();

    // Single requester: 2-cycle latency, one ready pulse, byte 0F on the wire
    base = log_a.size();
    rem_a[0] = 1; dat_a[0] = 8'h0F; drive();
    tick();
    check("t1_grant", gr_a, 4'b0001);
    check("t1_valid_early", txv_a, 0);
    check("t1_arb_busy", abusy_a, 1);
    tick();
    check("t1_tx_valid", txv_a, 1);
    check("t1_req_ready", rr_a, 4'b0001);
    check("t1_tx_data", txd_a, 8'h0F);
    tick();
    check("t1_ready_once", rr_a, 0);
    check("t1_valid_dropped", txv_a, 0);
    wait_quiet("t1_quiet");
    check("t1_frames", log_a.size() - base, 1);
    check("t1_byte", log_at(0, base), 16'h000F);
    check("t1_ready_cnt", rdy_cnt_a[0], 1);

    // MAX_BURST=1: strict per-byte rotation over four requesters
    for (int i = 0; i < N; i++) begin
      rem_b[i] = 2; dat_b[i] = 8'hA0 + 8'(i);
    end
    drive();
    wait_quiet("t2_quiet");
    check("t2_frames", log_b.size(), 8);
    for (int k = 0; k < 8; k++) begin
      exp_e = {6'd0, 2'(rr1_gid[k]), 8'hA0 + 8'(rr1_gid[k])};
      check($sformatf("t2_order%0d", k), log_at(1, k), exp_e);
    end

    // Burst cap: 8 from req2, then req3, then req2's remaining 2
    base = log_a.size();
    rem_a[2] = 10; dat_a[2] = 8'h20;
    rem_a[3] = 1;  dat_a[3] = 8'h30;
    drive();
    wait_quiet("t3_quiet");
    check("t3_frames", log_a.size() - base, 11);
    for (int k = 0; k < 11; k++) begin
      if (k < 8)       exp_e = {8'd2, 8'h20 + 8'(k)};
      else if (k == 8) exp_e = {8'd3, 8'h30};
      else             exp_e = {8'd2, 8'h20 + 8'(k - 1)};
      check($sformatf("t3_seq%0d", k), log_at(0, base + k), exp_e);
    end

    // Withdraw between grant and LATCH; rr_ptr must move to 2
    base = log_a.size();
    rem_a[1] = 1; dat_a[1] = 8'h11; drive();
    tick();
    check("t4_grant", gr_a, 4'b0010);
    rem_a[1] = 0; drive();
    tick();
    check("t4_released", gr_a, 0);
    check("t4_idle", abusy_a, 0);
    check("t4_no_ready", rr_a, 0);
    check("t4_no_valid", txv_a, 0);
    tick();
    check("t4_ready_cnt", rdy_cnt_a[1], 0);
    rem_a[1] = 1; rem_a[2] = 1; dat_a[2] = 8'h22; drive();
    tick();
    check("t4_rr_ptr", gid_a, 2);
    wait_quiet("t4_quiet");
    check("t4_frames", log_a.size() - base, 2);
    check("t4_first", log_at(0, base), 16'h0222);
    check("t4_second", log_at(0, base + 1), 16'h0111);

    // Core busy for 40 cycles while SEND waits: valid and data hold, one frame results
    base = log_a.size();
    hold_a = 1'b1;
    rem_a[0] = 1; dat_a[0] = 8'h5A; drive();
    tick(); tick();
    check("t5_valid", txv_a, 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (txv_a !== 1'b1 || txd_a !== 8'h5A) bad++;
    end
    check("t5_stable", bad, 0);
    hold_a = 1'b0;
    wait_quiet("t5_quiet");
    check("t5_frames", log_a.size() - base, 1);
    check("t5_byte", log_at(0, base), 16'h005A);

    // Reset while waiting for the end of a frame
    rem_a[3] = 2; dat_a[3] = 8'h40; drive();
    bad = 0;
    while (!busy_a && bad < 50) begin
      tick();
      bad++;
    end
    check("t6_started", busy_a, 1);
    tick();
    check("t6_in_wait_end", {abusy_a, txv_a}, 2'b10);
    rst = 1'b1;
    tick();
    check("t6_grant", gr_a, 0);
    check("t6_grant_id", gid_a, 0);
    check("t6_tx_data", txd_a, 0);
    check("t6_tx_valid", txv_a, 0);
    check("t6_req_ready", rr_a, 0);
    check("t6_arb_busy", abusy_a, 0);
    rst = 1'b0;
    wait_quiet("t6_quiet");

    // req1 leaves rr_ptr at 2; then req0 and req2 contend
    rem_a[1] = 1; dat_a[1] = 8'h61; drive();
    wait_quiet("t7_setup");
    rem_a[0] = 1; rem_a[2] = 1; drive();
    tick();
`ifdef UART_TX_ARB_PRIO0_EN
    check("t7_first_owner", gid_a, 0);
`else
    check("t7_first_owner", gid_a, 2);
`endif
    wait_quiet("t7_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
